result_copy_scheduler: RTL

- Shares the single result-copy engine (on-chip result RAM → FIFO → host-memory writer) between NUM_REQ result producers, e.g. per-lane word-count tables.
- Round-robin arbitration; per grant: drive offset/words/memory_addr, pulse kick, track engine busy, return a one-cycle done to the winner.
- Zero-length requests complete locally; watchdog flags a hung engine.

---
 rtl/result_copy_scheduler_pkg.sv | 19 +
 rtl/result_copy_scheduler_rr_arbiter.sv | 29 ++
 rtl/result_copy_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/result_copy_scheduler_pkg.sv
// Shared types and constants for the result-copy scheduler.
package result_copy_pkg;

  localparam int OFFSET_W      = 32;
  localparam int WORDS_W       = 32;
  localparam int ADDR_W        = 64;
  localparam int CNT_W         = 32;
  // Cycles the engine gets to raise busy after a kick before we give up.
  localparam int START_TIMEOUT = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    ZERO
  } state_t;

endpackage

// File: rtl/result_copy_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       gnt_vld,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/result_copy_scheduler.sv
// Shares one result-copy engine between NUM_REQ producers with round-robin
// grants, local completion of zero-length requests and a hang watchdog.
module result_copy_scheduler
  import result_copy_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*OFFSET_W-1:0]  req_offset,
  input  logic [NUM_REQ*WORDS_W-1:0]   req_words,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_memory_addr,
  output logic [NUM_REQ-1:0]           done,
  output logic                         copy_kick,
  input  logic                         copy_busy,
  output logic [OFFSET_W-1:0]          copy_offset,
  output logic [WORDS_W-1:0]           copy_words,
  output logic [ADDR_W-1:0]            copy_memory_addr,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         error,
  output logic [CNT_W-1:0]             completed_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [OFFSET_W-1:0] off_a   [NUM_REQ];
  logic [WORDS_W-1:0]  words_a [NUM_REQ];
  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign off_a[g]   = req_offset[OFFSET_W*g +: OFFSET_W];
    assign words_a[g] = req_words[WORDS_W*g +: WORDS_W];
    assign addr_a[g]  = req_memory_addr[ADDR_W*g +: ADDR_W];
  end

  state_t           state, state_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic [CNT_W-1:0] wait_cnt;
  logic             take;
  logic             finish;
  logic             kick_d;
  logic             err_set;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  // Next-state and per-cycle decisions; every output is registered below.
  always_comb begin
    state_d = state;
    take    = 1'b0;
    finish  = 1'b0;
    kick_d  = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (!copy_busy && arb_vld) begin
          take    = 1'b1;
          state_d = (words_a[arb_idx] == '0) ? ZERO : ISSUE;
        end
      end
      ISSUE: begin
        kick_d  = 1'b1;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (copy_busy) begin
          state_d = WAIT_DONE;
        end else if (wait_cnt == CNT_W'(START_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!copy_busy) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 &&
                     wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      ZERO: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and the wait counter, which restarts on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) begin
        wait_cnt <= '0;
      end else if (state == WAIT_START || state == WAIT_DONE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Grant capture, engine arguments, completion bookkeeping and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id         <= '0;
      rr_ptr           <= '0;
      copy_offset      <= '0;
      copy_words       <= '0;
      copy_memory_addr <= '0;
      copy_kick        <= 1'b0;
      done             <= '0;
      active           <= 1'b0;
      error            <= 1'b0;
      completed_count  <= '0;
    end else begin
      copy_kick <= kick_d;
      active    <= (state_d == ISSUE) || (state_d == WAIT_START) ||
                   (state_d == WAIT_DONE);
      done      <= finish ? (NUM_REQ'(1) << grant_id) : '0;
      if (take) begin
        grant_id         <= arb_idx;
        copy_offset      <= off_a[arb_idx];
        copy_words       <= words_a[arb_idx];
        copy_memory_addr <= addr_a[arb_idx];
      end
      if (finish) begin
        rr_ptr          <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        completed_count <= completed_count + 1'b1;
      end
      if (err_set) begin
        error <= 1'b1;
      end
    end
  end

endmodule
